// File: rtl/comparador_serie_der_izq_pkg.sv
// Shared definitions for the right-to-left bit-serial magnitude comparator.
// Encoding 2'd3 is unused and recovers to ST_IDLE.
package comparador_serie_der_izq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/celda_tipica_der_izq.sv
// Right-to-left comparator cell. A differing bit pair at this position
// overrides the running (x,y) flags from lower positions.
module celda_tipica_der_izq (
  input  logic A,
  input  logic B,
  input  logic x,
  input  logic y,
  output logic X,
  output logic Y
);

  always_comb begin
    X = x;
    Y = y;
    if (A & ~B) begin
      X = 1'b1;
      Y = 1'b0;
    end else if (~A & B) begin
      X = 1'b0;
      Y = 1'b1;
    end
  end

endmodule

// File: rtl/comparador_serie_der_izq.sv
// Bit-serial magnitude comparator, LSB first. After N accepted beats it
// pulses done and registers X (A>B) / Y (A<B).
//
// Handshake: a bit pair is consumed on a rising clk edge where bit_valid and
// ready are both high; ready is high only in SHIFT, so bits offered in IDLE
// or DONE are never consumed, and bit_valid may drop for any number of cycles.
module comparador_serie_der_izq
  import comparador_serie_der_izq_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       bit_valid,
  input  logic       A,
  input  logic       B,
  output logic       ready,
  output logic       done,
  output logic       X,
  output logic       Y,
  output logic       EQ,
  output logic [1:0] state_dbg
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          xr, yr;
  logic          nx, ny;
  logic          accept;

  celda_tipica_der_izq u_celda (
    .A (A),
    .B (B),
    .x (xr),
    .y (yr),
    .X (nx),
    .Y (ny)
  );

  assign accept    = bit_valid & ready;
  assign EQ        = ~X & ~Y;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      xr    <= 1'b0;
      yr    <= 1'b0;
      ready <= 1'b0;
      done  <= 1'b0;
      X     <= 1'b0;
      Y     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            count <= '0;
            xr    <= 1'b0;
            yr    <= 1'b0;
            ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (accept) begin
            xr    <= nx;
            yr    <= ny;
            count <= count + CW'(1);
            // Result goes straight to X/Y so it is visible during the done cycle.
            if (count == LAST) begin
              state <= ST_DONE;
              ready <= 1'b0;
              done  <= 1'b1;
              X     <= nx;
              Y     <= ny;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_serie_der_izq.sv
// Bench for comparador_serie_der_izq: directed scenarios plus randomized
// compares checked against an integer-magnitude reference model.
module tb_comparador_serie_der_izq;
  import comparador_serie_der_izq_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       bit_valid;
  logic       A;
  logic       B;
  logic       ready;
  logic       done;
  logic       X;
  logic       Y;
  logic       EQ;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];
  logic       held_x = 1'b0;
  logic       held_y = 1'b0;

  comparador_serie_der_izq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_valid (bit_valid),
    .A         (A),
    .B         (B),
    .ready     (ready),
    .done      (done),
    .X         (X),
    .Y         (Y),
    .EQ        (EQ),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the serial scan must agree with plain unsigned magnitude compare.
  function automatic logic [1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    return {ia > ib, ia < ib};
  endfunction

  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Driver: one full compare. Entered and left mid-cycle (#1 after an edge).
  // gap: idle cycles before each beat; spurious: pulse start during SHIFT;
  // chain: raise start in the done cycle so the next start lands in cycle N+2.
  task automatic run_compare(input logic [N-1:0] a, input logic [N-1:0] b,
                             input int gap, input bit spurious, input bit chain);
    logic [1:0] exp;
    exp_q.push_back(model(a, b));
    start = 1'b1;
    bit_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("ready_after_start", ready, 1'b1);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        bit_valid = 1'b0;
        A = $urandom_range(0, 1);
        B = $urandom_range(0, 1);
        tick();
        chk("ready_in_gap", ready, 1'b1);
        chk("no_done_in_gap", done, 1'b0);
      end
      bit_valid = 1'b1;
      A = a[i];
      B = b[i];
      if (spurious && i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (i < N - 1) begin
        chk("ready_mid_shift", ready, 1'b1);
        chk("no_done_mid_shift", done, 1'b0);
        chk("x_held_mid", X, held_x);
        chk("y_held_mid", Y, held_y);
      end
    end
    bit_valid = 1'b0;
    exp = exp_q.pop_front();
    chk("done_pulse", done, 1'b1);
    chk("ready_low_in_done", ready, 1'b0);
    chk("result_x", X, exp[1]);
    chk("result_y", Y, exp[0]);
    chk("result_eq", EQ, ~exp[1] & ~exp[0]);
    held_x = exp[1];
    held_y = exp[0];
    if (chain) start = 1'b1;
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("ready_low_idle", ready, 1'b0);
    chk("x_held_idle", X, held_x);
    chk("y_held_idle", Y, held_y);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bit_valid = 1'b0;
    A = 1'b0;
    B = 1'b0;
    tick();
    chk("rst_ready", ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_x", X, 1'b0);
    chk("rst_y", Y, 1'b0);
    chk("rst_eq", EQ, 1'b1);
    chk("rst_state_idle", state_dbg == ST_IDLE, 1'b1);
    reset = 1'b0;
    tick();
    held_x = 1'b0;
    held_y = 1'b0;
  endtask

  task automatic test_directed();
    run_compare(4'b1010, 4'b0110, 0, 1'b0, 1'b0);  // T1
    run_compare(4'b0011, 4'b1100, 0, 1'b0, 1'b0);  // T2
    run_compare(4'b0001, 4'b1000, 0, 1'b0, 1'b0);  // MSB overrides LSB
    run_compare(4'b1001, 4'b1001, 0, 1'b0, 1'b0);  // T3
    run_compare(4'b1010, 4'b0110, 2, 1'b0, 1'b0);  // T4 gaps
  endtask

  task automatic test_idle_bit_not_consumed();
    // A bit offered together with start must not count as a beat.
    start = 1'b1;
    bit_valid = 1'b1;
    A = 1'b0;
    B = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      bit_valid = 1'b1;
      A = 1'b1;
      B = 1'b1;
      tick();
      chk("idle_bit_no_early_done", done, (i == N - 1) ? 1'b1 : 1'b0);
    end
    bit_valid = 1'b0;
    chk("idle_bit_x", X, 1'b0);
    chk("idle_bit_y", Y, 1'b0);
    held_x = 1'b0;
    held_y = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    run_compare(4'b1111, 4'b0000, 0, 1'b0, 1'b0);  // leave X=1 so reset has something to clear
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bit_valid = 1'b1;
      A = i[0] ? 1'b1 : 1'b1;
      B = 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_x", X, 1'b0);
    chk("midrst_y", Y, 1'b0);
    chk("midrst_idle", state_dbg == ST_IDLE, 1'b1);
    tick();
    reset = 1'b0;
    held_x = 1'b0;
    held_y = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_done", done, 1'b0);
    end
    run_compare(4'b1010, 4'b0110, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_compare(4'b1100, 4'b0011, 0, 1'b1, 1'b1);  // start in SHIFT ignored
    run_compare(4'b0101, 4'b0110, 0, 1'b0, 1'b1);  // starts in cycle N+2
    run_compare(4'b0111, 4'b0111, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      run_compare(N'($urandom), N'($urandom), $urandom_range(0, 2),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_bit_not_consumed();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
